// File: rtl/prio_enc_sync.sv
// Clocked priority encoder for raw switch inputs: per-bit synchroniser, whole-vector debounce,
// then fixed-priority or round-robin encoding into a registered index with valid and change flag.
module prio_enc_sync #(
  parameter int unsigned N            = 8,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 4,
  localparam int unsigned W           = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sw,
  input  logic         mode,
  input  logic         out_ready,
  output logic [W-1:0] led_idx,
  output logic         led_valid,
  output logic         led_chg
);

  // Counter only has to reach DEBOUNCE_CYC-1, where it saturates.
  localparam int unsigned CntW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYC - 1);
  localparam logic [W-1:0] PtrInit = W'(N - 1);

  logic [SYNC_STAGES-1:0][N-1:0] sync_ff;
  logic [N-1:0]                  sync;
  logic [N-1:0]                  cand;
  logic [CntW-1:0]               cnt;
  logic [N-1:0]                  sw_db;
  logic [W-1:0]                  ptr;

  logic         accept;
  logic [W-1:0] eptr;
  logic [W-1:0] enc_idx;
  logic         enc_valid;
  logic         enc_chg;

  assign sync = sync_ff[SYNC_STAGES-1];

  // Synchroniser shift chain, stage 0 captures the raw switches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], sw};
    end
  end

  // Whole-vector debounce: any change restarts the count; a held value is committed once the
  // count saturates, so it has to be seen DEBOUNCE_CYC+1 times in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand  <= '0;
      cnt   <= '0;
      sw_db <= '0;
    end else if (sync != cand) begin
      cand <= sync;
      cnt  <= '0;
    end else if (cnt == CntMax) begin
      sw_db <= cand;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Encoder: highest set bit in fixed mode, next set bit after the effective pointer in
  // round-robin mode. On an accept the scan starts past the index being consumed right now,
  // so the same request is not granted twice in a row while others are pending.
  always_comb begin
    logic         found;
    logic [W:0]   sum;
    logic [W-1:0] j;
    accept    = mode & led_valid & out_ready;
    eptr      = accept ? led_idx : ptr;
    enc_idx   = '0;
    enc_valid = |sw_db;
    found     = 1'b0;
    sum       = '0;
    j         = '0;
    if (!mode) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (sw_db[W'(i)]) begin
          enc_idx = W'(i);
        end
      end
    end else begin
      for (int unsigned k = 1; k <= N; k++) begin
        sum = {1'b0, eptr} + (W+1)'(k);
        if (sum >= (W+1)'(N)) begin
          sum = sum - (W+1)'(N);
        end
        j = sum[W-1:0];
        if (!found && sw_db[j]) begin
          found   = 1'b1;
          enc_idx = j;
        end
      end
    end
    enc_chg = (enc_idx != led_idx) || (enc_valid != led_valid);
  end

  // Registered outputs and round-robin pointer; the pointer only moves on an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_idx   <= '0;
      led_valid <= 1'b0;
      led_chg   <= 1'b0;
      ptr       <= PtrInit;
    end else begin
      led_idx   <= enc_idx;
      led_valid <= enc_valid;
      led_chg   <= enc_chg;
      if (accept) begin
        ptr <= led_idx;
      end
    end
  end

endmodule

// File: tb/tb_prio_enc_sync.sv
// Scoreboard bench for prio_enc_sync (N=4): directed scenarios plus randomized switch traffic,
// checked against a reference model built on delay-line / window / cyclic-scan rules.
module tb_prio_enc_sync;

  localparam int unsigned NB = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned DC = 4;
  localparam int unsigned WB = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NB-1:0] sw = '0;
  logic          mode = 1'b0;
  logic          out_ready = 1'b0;
  logic [WB-1:0] led_idx;
  logic          led_valid;
  logic          led_chg;

  prio_enc_sync #(
    .N           (NB),
    .SYNC_STAGES (SS),
    .DEBOUNCE_CYC(DC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .mode     (mode),
    .out_ready(out_ready),
    .led_idx  (led_idx),
    .led_valid(led_valid),
    .led_chg  (led_chg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int valid;
    int chg;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int m_idx, m_valid, m_chg, m_ptr, m_db;
  int dly[$];   // switch samples still travelling through the synchroniser
  int hist[$];  // most recent synchronised samples seen by the debouncer

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic now_chk(input string name, input int idx, input int valid, input int chg);
    chk({name, "_idx"}, int'(led_idx), idx);
    chk({name, "_valid"}, int'(led_valid), valid);
    chk({name, "_chg"}, int'(led_chg), chg);
  endtask

  function automatic void encode(input int db, input int md, input int eptr,
                                 output int idx, output int valid);
    idx   = 0;
    valid = (db != 0) ? 1 : 0;
    if (db != 0) begin
      if (md == 0) begin
        for (int i = NB - 1; i >= 0; i--) begin
          if (((db >> i) & 1) == 1) begin
            idx = i;
            break;
          end
        end
      end else begin
        for (int k = 1; k <= NB; k++) begin
          int c;
          c = (eptr + k) % NB;
          if (((db >> c) & 1) == 1) begin
            idx = c;
            break;
          end
        end
      end
    end
  endfunction

  function automatic void model_reset();
    m_idx   = 0;
    m_valid = 0;
    m_chg   = 0;
    m_ptr   = NB - 1;
    m_db    = 0;
    dly.delete();
    for (int i = 0; i < SS; i++) dly.push_back(0);
    hist.delete();
    hist.push_back(0);
  endfunction

  // One rising edge of the reference: outputs from the current debounced vector, then the
  // debounced vector takes a value once the last DC+1 synchronised samples all agree.
  function automatic void model_edge();
    int acc, eptr, nidx, nvalid, s;
    bit same;
    acc  = (mode && (m_valid != 0) && out_ready) ? 1 : 0;
    eptr = (acc != 0) ? m_idx : m_ptr;
    encode(m_db, int'(mode), eptr, nidx, nvalid);
    m_chg = ((nidx != m_idx) || (nvalid != m_valid)) ? 1 : 0;
    if (acc != 0) m_ptr = m_idx;
    m_idx   = nidx;
    m_valid = nvalid;
    s = dly.pop_front();
    dly.push_back(int'(sw));
    hist.push_back(s);
    if (hist.size() > DC + 1) void'(hist.pop_front());
    if (hist.size() == DC + 1) begin
      same = 1'b1;
      foreach (hist[i]) if (hist[i] != s) same = 1'b0;
      if (same) m_db = s;
    end
  endfunction

  task automatic step();
    exp_t e;
    @(posedge clk);
    model_edge();
    e.idx   = m_idx;
    e.valid = m_valid;
    e.chg   = m_chg;
    sb.push_back(e);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Assert reset between edges, check outputs clear with no clock, hold, release on a negedge.
  task automatic do_reset(input int hold);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    now_chk("rst_async", 0, 0, 0);
    model_reset();
    repeat (hold) begin
      @(posedge clk);
      #1;
      now_chk("rst_hold", 0, 0, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares each registered result half a cycle after its edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_idx", int'(led_idx), e.idx);
        chk("sb_valid", int'(led_valid), e.valid);
        chk("sb_chg", int'(led_chg), e.chg);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[6];
    int len;
    seq = '{0, 1, 3, 0, 1, 3};
    model_reset();

    // Reset holds everything at zero even with all switches on
    sw = 4'b1111;
    do_reset(3);
    step();
    now_chk("t1_post", 0, 0, 0);

    // Fixed priority, full latency to edge 8, one-cycle change pulse
    mode = 1'b0;
    out_ready = 1'b0;
    do_reset(2);
    sw = 4'b0101;
    run(7);
    now_chk("t2_edge7", 0, 0, 0);
    step();
    now_chk("t2_edge8", 2, 1, 1);
    step();
    now_chk("t2_edge9", 2, 1, 0);

    // Short pulse is filtered, 5-cycle pulse gets through
    do_reset(2);
    sw = 4'b0001;
    run(4);
    sw = 4'b0000;
    run(12);
    now_chk("t3_glitch", 0, 0, 0);
    sw = 4'b0001;
    run(5);
    sw = 4'b0000;
    run(3);
    now_chk("t3_pulse", 0, 1, 1);
    run(12);
    now_chk("t3_drop", 0, 0, 0);

    // Round-robin with ready held high
    mode = 1'b1;
    out_ready = 1'b1;
    do_reset(2);
    sw = 4'b1011;
    run(7);
    for (int i = 0; i < 6; i++) begin
      step();
      now_chk("t4_rr", seq[i], 1, 1);
    end

    // Round-robin waiting on the consumer, then a single accept
    out_ready = 1'b0;
    do_reset(2);
    sw = 4'b1011;
    run(7);
    repeat (10) begin
      step();
      chk("t5_hold_idx", int'(led_idx), 0);
      chk("t5_hold_valid", int'(led_valid), 1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t5_accept_idx", int'(led_idx), 1);
    repeat (3) begin
      step();
      chk("t5_after_idx", int'(led_idx), 1);
      chk("t5_after_chg", int'(led_chg), 0);
    end

    // Reset mid-rotation loses all progress
    out_ready = 1'b1;
    run(5);
    do_reset(1);
    run(7);
    now_chk("t6_edge7", 0, 0, 0);
    step();
    now_chk("t6_edge8", 0, 1, 1);

    // Randomized traffic: random vectors, hold lengths, mode flips, ready, occasional reset
    repeat (60) begin
      if ($urandom_range(0, 14) == 0) do_reset(1);
      sw = NB'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) mode = ~mode;
      len = int'($urandom_range(1, 12));
      repeat (len) begin
        out_ready = 1'($urandom_range(0, 1));
        step();
      end
    end

    @(negedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
